// File: rtl/multicycle_main_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_main_ctrl_if
// Purpose : Bundles the signals between the multi-cycle MIPS main control FSM
//           and the datapath/memory it sequences.
// Signals :
//   opcode        IR[31:26], valid from DECODE onward (datapath -> ctrl)
//   mem_ready     memory completes current read/write this cycle (mem -> ctrl)
//   pc_write      unconditional PC load
//   pc_write_cond PC load if ALU zero
//   i_or_d        memory address select: 0=PC, 1=ALUOut
//   mem_read      memory read request
//   mem_write     memory write request
//   ir_write      load IR from memory data
//   mem_to_reg    register write data: 0=ALUOut, 1=MDR
//   reg_dst       destination register: 0=rt, 1=rd
//   reg_write     register file write enable
//   alu_src_a     ALU A: 0=PC, 1=rs
//   alu_src_b     ALU B: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2
//   alu_op        00=add, 01=sub, 10=funct-decoded
//   pc_source     00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op    one-cycle pulse after an unsupported opcode in DECODE
//   state         current FSM state encoding (debug)
// Modports: master = control FSM, slave = datapath side.
// ----------------------------------------------------------------------------
interface multicycle_main_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_main_ctrl
// Purpose : Main control FSM of the multi-cycle MIPS datapath. Sequences
//           fetch/decode/execute/memory/writeback from the IR opcode and drives
//           the datapath mux selects, enables and the 2-bit ALUOp. Memory steps
//           (FETCH, MEM_RD, MEM_WR) stall until mem_ready.
// Ports   :
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   io_bus  control interface (master side): opcode/mem_ready in, controls out
// ----------------------------------------------------------------------------
module multicycle_main_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_J     = 6'd2,
    parameter logic [5:0] OP_ADDI  = 6'd8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    multicycle_main_ctrl_if.master       io_bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_illegal;
    logic   w_illegal_next;

    logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StFetch;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEM_ADDR
    always_comb begin
        w_state_next   = StFetch;
        w_illegal_next = 1'b0;
        case (r_state)
            StFetch:   w_state_next = io_bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (io_bus.opcode)
                    OP_LW, OP_SW: w_state_next = StMemAddr;
                    OP_RTYPE:     w_state_next = StRExec;
                    OP_BEQ:       w_state_next = StBranch;
                    OP_J:         w_state_next = StJump;
                    OP_ADDI:      w_state_next = StIExec;
                    default: begin
                        w_state_next   = StFetch;
                        w_illegal_next = 1'b1;
                    end
                endcase
            end
            StMemAddr: begin
                if (io_bus.opcode == OP_LW) begin
                    w_state_next = StMemRd;
                end else if (io_bus.opcode == OP_SW) begin
                    w_state_next = StMemWr;
                end else begin
                    w_state_next = StFetch;
                end
            end
            StMemRd:   w_state_next = io_bus.mem_ready ? StMemWb : StMemRd;
            StMemWr:   w_state_next = io_bus.mem_ready ? StFetch : StMemWr;
            StRExec:   w_state_next = StRWb;
            StIExec:   w_state_next = StIWb;
            default:   w_state_next = StFetch;  // writebacks, branch, jump, unused codes
        endcase
    end

    // Output decode from state (FETCH's IR/PC load additionally waits on mem_ready)
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        case (r_state)
            StFetch: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = io_bus.mem_ready;
                w_pc_write  = io_bus.mem_ready;
            end
            StDecode:  w_alu_src_b = 2'b11;
            StMemAddr: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            StMemRd: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
            end
            StMemWb: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            StMemWr: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
            end
            StRExec: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            StRWb: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            StBranch: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            StJump: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
            StIExec: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            StIWb:     w_reg_write = 1'b1;
            default: ;
        endcase
    end

    // Enables are suppressed during reset so an aborted instruction cannot write
    assign io_bus.pc_write      = w_pc_write      & ~i_rst;
    assign io_bus.pc_write_cond = w_pc_write_cond & ~i_rst;
    assign io_bus.mem_read      = w_mem_read      & ~i_rst;
    assign io_bus.mem_write     = w_mem_write     & ~i_rst;
    assign io_bus.ir_write      = w_ir_write      & ~i_rst;
    assign io_bus.reg_write     = w_reg_write     & ~i_rst;
    assign io_bus.i_or_d        = w_i_or_d;
    assign io_bus.mem_to_reg    = w_mem_to_reg;
    assign io_bus.reg_dst       = w_reg_dst;
    assign io_bus.alu_src_a     = w_alu_src_a;
    assign io_bus.alu_src_b     = w_alu_src_b;
    assign io_bus.alu_op        = w_alu_op;
    assign io_bus.pc_source     = w_pc_source;
    assign io_bus.illegal_op    = r_illegal;
    assign io_bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_main_ctrl
// Purpose : Drives instruction opcodes and randomized memory-ready stalls into
//           the main control FSM and compares state and control outputs each
//           cycle against a phase-list model of each instruction class.
// ----------------------------------------------------------------------------
module tb_multicycle_main_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_main_ctrl_if bus_if ();

    multicycle_main_ctrl dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit illegal_pending = 1'b0;

    // Bit order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
    localparam logic [15:0] EN_MASK = 16'hDC80;

    // Instruction plan: sequence of states visited with no stalls
    typedef struct packed {
        logic [2:0]      n;
        logic [5:0][3:0] s;
    } plan_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] obs_vec();
        return {bus_if.pc_write, bus_if.pc_write_cond, bus_if.i_or_d, bus_if.mem_read,
                bus_if.mem_write, bus_if.ir_write, bus_if.mem_to_reg, bus_if.reg_dst,
                bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
                bus_if.pc_source};
    endfunction

    // Expected controls for each state, straight from the state descriptions
    function automatic logic [15:0] exp_vec(input int st, input bit mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rwr = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rwr = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rwr = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, psrc};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
    endfunction

    function automatic plan_t plan_for(input logic [5:0] op);
        plan_t p;
        p = '0;
        p.s[0] = 4'd0;
        p.s[1] = 4'd1;
        case (op)
            6'd0:  begin p.n = 4; p.s[2] = 4'd6;  p.s[3] = 4'd7;  end
            6'd35: begin p.n = 5; p.s[2] = 4'd2;  p.s[3] = 4'd3;  p.s[4] = 4'd4; end
            6'd43: begin p.n = 4; p.s[2] = 4'd2;  p.s[3] = 4'd5;  end
            6'd4:  begin p.n = 3; p.s[2] = 4'd8;  end
            6'd2:  begin p.n = 3; p.s[2] = 4'd9;  end
            6'd8:  begin p.n = 4; p.s[2] = 4'd10; p.s[3] = 4'd11; end
            default: p.n = 2;
        endcase
        return p;
    endfunction

    // Runs one instruction from FETCH; memory phases stall while mem_ready=0.
    // With abort set, reset is raised on the first MEM_RD cycle.
    task automatic run_instr(input logic [5:0] op, input bit stalls, input bit abort);
        plan_t p;
        int    idx;
        int    st;
        bit    mr;
        bit    first;
        p     = plan_for(op);
        idx   = 0;
        first = 1'b1;
        while (idx < int'(p.n)) begin
            st = int'(p.s[idx]);
            if (abort && st == 3) begin
                rst = 1'b1;
                bus_if.mem_ready = 1'b1;
                bus_if.opcode = 6'($urandom);
                @(negedge clk);
                check("abort_state", 32'(bus_if.state), 32'd3);
                check("abort_enables", 32'(obs_vec() & EN_MASK), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                illegal_pending = 1'b0;
                return;
            end
            mr = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus_if.mem_ready = mr;
            // Opcode only needs to be valid where it is sampled; scramble it elsewhere
            bus_if.opcode = (st == 1 || st == 2) ? op : 6'($urandom);
            @(negedge clk);
            check($sformatf("state op%0d", op), 32'(bus_if.state), 32'(st));
            check($sformatf("ctrl op%0d st%0d", op, st), 32'(obs_vec()), 32'(exp_vec(st, mr)));
            check($sformatf("illegal_op op%0d st%0d", op, st), 32'(bus_if.illegal_op),
                  32'(first && illegal_pending));
            @(posedge clk);
            #1;
            first = 1'b0;
            if (!((st == 0 || st == 3 || st == 5) && !mr)) idx++;
        end
        illegal_pending = !is_legal(op);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        legal_ops[0] = 6'd0;  legal_ops[1] = 6'd35; legal_ops[2] = 6'd43;
        legal_ops[3] = 6'd4;  legal_ops[4] = 6'd2;  legal_ops[5] = 6'd8;

        rst = 1'b1;
        bus_if.mem_ready = 1'b1;
        bus_if.opcode = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(bus_if.state), 32'd0);
        check("reset_enables", 32'(obs_vec() & EN_MASK), 32'd0);
        check("reset_illegal", 32'(bus_if.illegal_op), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: each class once, plus illegal followed by a legal op
        run_instr(6'd0, 1'b0, 1'b0);
        run_instr(6'd35, 1'b1, 1'b0);
        run_instr(6'd43, 1'b0, 1'b0);
        run_instr(6'd4, 1'b0, 1'b0);
        run_instr(6'd2, 1'b0, 1'b0);
        run_instr(6'd63, 1'b0, 1'b0);
        run_instr(6'd8, 1'b0, 1'b0);
        run_instr(6'd17, 1'b1, 1'b0);
        run_instr(6'd0, 1'b1, 1'b0);

        // Random mix of opcodes and stall patterns
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(op, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset while waiting in MEM_RD, then make sure execution resumes cleanly
        run_instr(6'd35, 1'b0, 1'b1);
        run_instr(6'd0, 1'b0, 1'b0);
        run_instr(6'd35, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
